latency_ram: RTL and testbench
==============================

LATENCY_RAM -- requirements
Module: latency_ram

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 8, word-address bits (array depth 2**ADDR_WIDTH words of 32 bits).
REQ-002 SHALL have parameter READ_LATENCY, default 1, clock edges from read acceptance to data capture; legal range 1..8.
REQ-003 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have port resetn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port mem_addr  input  32  byte address; word index = mem_addr[ADDR_WIDTH+1:2], bits [1:0] ignored.
REQ-006 SHALL have port mem_rstrb  input  1  read request, sampled on rising edge.
REQ-007 SHALL have port mem_wdata  input  32  write data.
REQ-008 SHALL have port mem_wmask  input  4  byte write enables, bit i writes mem_wdata[8i+7:8i]; nonzero = write request.
REQ-009 SHALL have port mem_rdata  output  32  registered read data, held until the next completed read.
REQ-010 SHALL have port mem_rbusy  output  1  high while an accepted read is outstanding.
REQ-011 SHALL have port mem_ready  output  1  one-cycle pulse: mem_rdata newly valid.
REQ-012 SHALL have port mem_err  output  1  one-cycle pulse: last accepted request addressed beyond the array.

Function
REQ-013 SHALL accept a request on a rising edge only when mem_rbusy is low; requests while mem_rbusy is high are ignored (no write, no read, no error).
REQ-014 SHALL perform an accepted write in the accept edge, updating only the bytes enabled in mem_wmask; disabled bytes keep prior values.
REQ-015 SHALL latch the word index at read acceptance; mem_addr may change afterwards without effect.
REQ-016 SHALL use states IDLE and WAIT plus a down-counter: IDLE + read accepted -> counter = READ_LATENCY-1; if 0 capture data at that edge and stay IDLE, else go WAIT.
REQ-017 SHALL in WAIT decrement the counter each edge and capture data and return to IDLE on the edge where counter is 1.
REQ-018 SHALL drive mem_rbusy = 1 exactly while in WAIT (never for READ_LATENCY=1).
REQ-019 SHALL assert mem_ready for exactly the one cycle following the data-capture edge.
REQ-020 SHALL, for READ_LATENCY=1, deliver data in the cycle after mem_rstrb is sampled, permitting back-to-back reads every cycle.
REQ-021 SHALL treat simultaneous mem_rstrb and nonzero mem_wmask as read-before-write: the write is performed and the read returns the pre-write word.
REQ-022 SHALL flag an access out of range when mem_addr[31:ADDR_WIDTH+2] is nonzero: write dropped, read completes normally with mem_rdata = 0, mem_err pulses the cycle after the accept edge.
REQ-023 SHALL leave mem_rdata unchanged when no read completes.
REQ-024 SHALL not initialise or reset array contents; the bench preloads them.

Reset
REQ-025 SHALL, while resetn is low, force state IDLE, counter 0, mem_rdata 0, mem_rbusy 0, mem_ready 0, mem_err 0, independent of clk.
REQ-026 SHALL abort an outstanding read when reset asserts mid-WAIT: no mem_ready pulse and mem_rdata stays 0 after release.
REQ-027 SHALL ignore requests on any edge where resetn is low, and accept requests from the first rising edge with resetn high.

Verification
REQ-028 Latency 1: preload word 5 = 0xDEADBEEF, mem_rstrb with addr 0x14 -> next cycle mem_rdata 0xDEADBEEF, mem_ready 1, mem_rbusy never high.
REQ-029 READ_LATENCY=4: read addr 0x08 (word 0x11223344), change addr next cycle -> mem_rbusy high 3 cycles, mem_ready 4th cycle, data 0x11223344.
REQ-030 Byte write: word 3 = 0xAABBCCDD, write 0x12345678 mask 4'b0101 at addr 0x0C, then read -> 0xAA34CC78.
REQ-031 Simultaneous read+write to 0x10 (old 0x0, new 0xFFFFFFFF mask 4'hF) -> read returns 0x0; subsequent read returns 0xFFFFFFFF.
REQ-032 Out-of-range with ADDR_WIDTH=8: write to 0x400 then read 0x400 -> mem_err pulses on both, word 0 unchanged, mem_rdata 0.
REQ-033 READ_LATENCY=4: assert resetn low 2 cycles after read accept, write request during WAIT before that -> no write, no mem_ready, mem_rdata 0 after reset release.

Source files
------------

// File: rtl/latency_ram.sv
// latency_ram: 32-bit word memory with a configurable read latency and
// byte-masked writes.
//
// Parameters
//   ADDR_WIDTH   : word-address bits, array holds 2**ADDR_WIDTH 32-bit words
//   READ_LATENCY : rising edges from read acceptance to data capture (1..8)
//
// Ports
//   clk        in   sole clock, rising edge
//   resetn     in   asynchronous active-low reset
//   mem_addr   in   byte address, word index = mem_addr[ADDR_WIDTH+1:2]
//   mem_rstrb  in   read request
//   mem_wdata  in   write data
//   mem_wmask  in   byte write enables, nonzero means write request
//   mem_rdata  out  registered read data, held until the next completed read
//   mem_rbusy  out  high while an accepted read is outstanding
//   mem_ready  out  one-cycle pulse, mem_rdata newly valid
//   mem_err    out  one-cycle pulse, last accepted request was out of range
//   dbg_state  out  FSM state (0 = IDLE, 1 = WAIT)
//
// Handshake: a request (mem_rstrb and/or nonzero mem_wmask) is accepted on a
// rising edge only when mem_rbusy is low and resetn is high; otherwise it is
// dropped entirely. A read completes with a mem_ready pulse READ_LATENCY
// cycles after acceptance; there is no back-pressure on the response.
module latency_ram #(
  parameter int ADDR_WIDTH   = 8,
  parameter int READ_LATENCY = 1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] mem_addr,
  input  logic        mem_rstrb,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wmask,
  output logic [31:0] mem_rdata,
  output logic        mem_rbusy,
  output logic        mem_ready,
  output logic        mem_err,
  output logic        dbg_state
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_e;

  localparam int         DEPTH  = 2 ** ADDR_WIDTH;
  localparam logic [3:0] LAT_M1 = 4'(READ_LATENCY - 1);

  logic [31:0] mem_array [DEPTH];

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] hold_q, hold_d;
  logic [31:0] rdata_q, rdata_d;
  logic        rbusy_q, rbusy_d;
  logic        ready_q, ready_d;
  logic        err_q, err_d;

  logic [ADDR_WIDTH-1:0] word_idx;
  logic                  out_of_range;
  logic                  accept;
  logic                  wr_acc;
  logic [31:0]           word_now;
  logic                  unused_addr_bits;

  assign word_idx         = mem_addr[ADDR_WIDTH+1:2];
  assign out_of_range     = (mem_addr >> (ADDR_WIDTH + 2)) != 32'd0;
  assign unused_addr_bits = ^mem_addr[1:0];
  assign accept           = (state_q == S_IDLE);
  // resetn gates the write because the array has no reset of its own.
  assign wr_acc           = accept && resetn && (mem_wmask != 4'd0) && !out_of_range;
  // Sampled before this edge's write lands, which gives read-before-write.
  assign word_now         = out_of_range ? 32'd0 : mem_array[word_idx];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    rdata_d = rdata_q;
    ready_d = 1'b0;
    err_d   = accept && (mem_rstrb || (mem_wmask != 4'd0)) && out_of_range;
    case (state_q)
      S_IDLE: begin
        if (mem_rstrb) begin
          cnt_d = LAT_M1;
          if (LAT_M1 == 4'd0) begin
            rdata_d = word_now;
            ready_d = 1'b1;
          end else begin
            // Snapshot now so a same-edge write cannot leak into the result.
            hold_d  = word_now;
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd1) begin
          rdata_d = hold_q;
          ready_d = 1'b1;
          cnt_d   = 4'd0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    rbusy_d = (state_d == S_WAIT);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      hold_q  <= 32'd0;
      rdata_q <= 32'd0;
      rbusy_q <= 1'b0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      rdata_q <= rdata_d;
      rbusy_q <= rbusy_d;
      ready_q <= ready_d;
      err_q   <= err_d;
    end
  end

  // Array contents are never reset; only enabled bytes are updated.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_wmask[b]) mem_array[word_idx][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
    end
  end

  assign mem_rdata = rdata_q;
  assign mem_rbusy = rbusy_q;
  assign mem_ready = ready_q;
  assign mem_err   = err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_latency_ram.sv
module tb_latency_ram;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_1, rst_4;
  logic [31:0] addr_1, wdata_1, rdata_1;
  logic [3:0]  wmask_1;
  logic        rstrb_1, rbusy_1, ready_1, err_1, dbg_1;
  logic [31:0] addr_4, wdata_4, rdata_4;
  logic [3:0]  wmask_4;
  logic        rstrb_4, rbusy_4, ready_4, err_4, dbg_4;

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  latency_ram #(.ADDR_WIDTH(8), .READ_LATENCY(1)) u_dut1 (
    .clk(clk), .resetn(rst_1), .mem_addr(addr_1), .mem_rstrb(rstrb_1),
    .mem_wdata(wdata_1), .mem_wmask(wmask_1), .mem_rdata(rdata_1),
    .mem_rbusy(rbusy_1), .mem_ready(ready_1), .mem_err(err_1), .dbg_state(dbg_1)
  );

  latency_ram #(.ADDR_WIDTH(8), .READ_LATENCY(4)) u_dut4 (
    .clk(clk), .resetn(rst_4), .mem_addr(addr_4), .mem_rstrb(rstrb_4),
    .mem_wdata(wdata_4), .mem_wmask(wmask_4), .mem_rdata(rdata_4),
    .mem_rbusy(rbusy_4), .mem_ready(ready_4), .mem_err(err_4), .dbg_state(dbg_4)
  );

  // ---------------- scoreboard check ----------------
  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Inputs change and outputs are sampled 1ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr1(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    addr_1 = a; wdata_1 = d; wmask_1 = m;
    tick();
    wmask_1 = 4'd0;
  endtask

  task automatic rd1(input logic [31:0] a);
    addr_1 = a; rstrb_1 = 1'b1;
    tick();
    rstrb_1 = 1'b0;
  endtask

  task automatic wr4(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    addr_4 = a; wdata_4 = d; wmask_4 = m;
    tick();
    wmask_4 = 4'd0;
  endtask

  // Read on the latency-4 instance. wm/wd are applied on the accept edge;
  // poke drives a read+write to 0x14 throughout the busy window.
  task automatic rd4(input logic [31:0] a, input logic [3:0] wm, input logic [31:0] wd,
                     input bit poke, output logic [31:0] data, output int lat,
                     output int busy, output logic err_first);
    addr_4 = a; rstrb_4 = 1'b1; wmask_4 = wm; wdata_4 = wd;
    tick();
    rstrb_4 = 1'b0; wmask_4 = 4'd0;
    if (poke) begin
      addr_4 = 32'h14; rstrb_4 = 1'b1; wmask_4 = 4'hF; wdata_4 = 32'hFFFF_FFFF;
    end
    err_first = err_4;
    lat  = 1;
    busy = 0;
    while (!ready_4 && lat < 20) begin
      busy += int'(rbusy_4);
      tick();
      lat++;
    end
    rstrb_4 = 1'b0; wmask_4 = 4'd0;
    data = rdata_4;
  endtask

  // ---------------- stimulus ----------------
  logic [31:0] d;
  int          lat, busy;
  logic        e;
  logic        saw_ready;

  initial begin
    rst_1 = 1'b0; rst_4 = 1'b0;
    addr_1 = '0; wdata_1 = '0; wmask_1 = '0; rstrb_1 = 1'b0;
    addr_4 = '0; wdata_4 = '0; wmask_4 = '0; rstrb_4 = 1'b0;
    repeat (2) tick();

    check_eq("reset rdata1", rdata_1, 32'd0);
    check_eq("reset rbusy1", 32'(rbusy_1), 32'd0);
    check_eq("reset ready1", 32'(ready_1), 32'd0);
    check_eq("reset err1",   32'(err_1),   32'd0);
    check_eq("reset rdata4", rdata_4, 32'd0);
    check_eq("reset rbusy4", 32'(rbusy_4), 32'd0);
    check_eq("reset ready4", 32'(ready_4), 32'd0);
    check_eq("reset err4",   32'(err_4),   32'd0);

    rst_1 = 1'b1; rst_4 = 1'b1;

    // ---- latency 1 ----
    wr1(32'h14, 32'hDEAD_BEEF, 4'hF);
    check_eq("l1 write no err", 32'(err_1), 32'd0);
    rd1(32'h14);
    check_eq("l1 rdata", rdata_1, 32'hDEAD_BEEF);
    check_eq("l1 ready", 32'(ready_1), 32'd1);
    check_eq("l1 rbusy", 32'(rbusy_1), 32'd0);
    tick();
    check_eq("l1 ready drop", 32'(ready_1), 32'd0);
    check_eq("l1 rdata hold", rdata_1, 32'hDEAD_BEEF);

    wr1(32'h0C, 32'hAABB_CCDD, 4'hF);
    wr1(32'h0C, 32'h1234_5678, 4'b0101);
    rd1(32'h0C);
    check_eq("l1 byte write", rdata_1, 32'hAA34_CC78);

    wr1(32'h10, 32'h0, 4'hF);
    addr_1 = 32'h10; rstrb_1 = 1'b1; wmask_1 = 4'hF; wdata_1 = 32'hFFFF_FFFF;
    tick();
    rstrb_1 = 1'b0; wmask_1 = 4'd0;
    check_eq("l1 rbw old", rdata_1, 32'h0);
    check_eq("l1 rbw ready", 32'(ready_1), 32'd1);
    rd1(32'h10);
    check_eq("l1 rbw new", rdata_1, 32'hFFFF_FFFF);

    for (int i = 0; i < 4; i++) wr1(32'h50 + 32'(4*i), 32'hA000_0000 + 32'(i), 4'hF);
    for (int i = 0; i < 4; i++) begin
      addr_1 = 32'h50 + 32'(4*i); rstrb_1 = 1'b1;
      exp_q.push_back(32'hA000_0000 + 32'(i));
      tick();
      check_eq("l1 b2b ready", 32'(ready_1), 32'd1);
      check_eq("l1 b2b rbusy", 32'(rbusy_1), 32'd0);
      check_eq("l1 b2b rdata", rdata_1, exp_q.pop_front());
    end
    rstrb_1 = 1'b0;

    wr1(32'h0, 32'hCAFE_F00D, 4'hF);
    wr1(32'h400, 32'h1234_5678, 4'hF);
    check_eq("l1 oor wr err", 32'(err_1), 32'd1);
    tick();
    check_eq("l1 oor err drop", 32'(err_1), 32'd0);
    rd1(32'h400);
    check_eq("l1 oor rd err", 32'(err_1), 32'd1);
    check_eq("l1 oor rd ready", 32'(ready_1), 32'd1);
    check_eq("l1 oor rdata", rdata_1, 32'd0);
    rd1(32'h0);
    check_eq("l1 word0 kept", rdata_1, 32'hCAFE_F00D);
    check_eq("l1 inrange no err", 32'(err_1), 32'd0);

    // requests during reset are ignored; reset acts without a clock edge
    wr1(32'h1C, 32'h0102_0304, 4'hF);
    rst_1 = 1'b0;
    #1;
    check_eq("l1 async rst rdata", rdata_1, 32'd0);
    addr_1 = 32'h1C; wdata_1 = 32'hFFFF_FFFF; wmask_1 = 4'hF; rstrb_1 = 1'b1;
    tick();
    check_eq("l1 rst no ready", 32'(ready_1), 32'd0);
    wmask_1 = 4'd0; rstrb_1 = 1'b0;
    rst_1 = 1'b1;
    rd1(32'h1C);
    check_eq("l1 rst no write", rdata_1, 32'h0102_0304);

    // ---- latency 4 ----
    wr4(32'h08, 32'h1122_3344, 4'hF);
    wr4(32'h14, 32'h9999_9999, 4'hF);
    wr4(32'h00, 32'h0F0F_0F0F, 4'hF);
    wr4(32'h10, 32'h0,         4'hF);
    wr4(32'h24, 32'h0BAD_F00D, 4'hF);

    rd4(32'h08, 4'd0, 32'd0, 1'b1, d, lat, busy, e);
    check_eq("l4 rdata", d, 32'h1122_3344);
    check_eq("l4 latency", 32'(lat), 32'd4);
    check_eq("l4 busy cycles", 32'(busy), 32'd3);
    check_eq("l4 rbusy at ready", 32'(rbusy_4), 32'd0);
    check_eq("l4 no err", 32'(e), 32'd0);
    tick();
    check_eq("l4 ready pulse", 32'(ready_4), 32'd0);
    rd4(32'h14, 4'd0, 32'd0, 1'b0, d, lat, busy, e);
    check_eq("l4 busy write ignored", d, 32'h9999_9999);

    wr4(32'h400, 32'h1234_5678, 4'hF);
    check_eq("l4 oor wr err", 32'(err_4), 32'd1);
    tick();
    check_eq("l4 oor err drop", 32'(err_4), 32'd0);
    rd4(32'h400, 4'd0, 32'd0, 1'b0, d, lat, busy, e);
    check_eq("l4 oor rd err", 32'(e), 32'd1);
    check_eq("l4 oor rdata", d, 32'd0);
    check_eq("l4 oor latency", 32'(lat), 32'd4);
    rd4(32'h00, 4'd0, 32'd0, 1'b0, d, lat, busy, e);
    check_eq("l4 word0 kept", d, 32'h0F0F_0F0F);

    rd4(32'h10, 4'hF, 32'hFFFF_FFFF, 1'b0, d, lat, busy, e);
    check_eq("l4 rbw old", d, 32'h0);
    rd4(32'h10, 4'd0, 32'd0, 1'b0, d, lat, busy, e);
    check_eq("l4 rbw new", d, 32'hFFFF_FFFF);

    // reset during WAIT aborts the read; a write issued while busy is dropped
    addr_4 = 32'h08; rstrb_4 = 1'b1;
    tick();
    rstrb_4 = 1'b0;
    addr_4 = 32'h24; wdata_4 = 32'hFFFF_FFFF; wmask_4 = 4'hF;
    tick();
    wmask_4 = 4'd0;
    check_eq("l4 busy before rst", 32'(rbusy_4), 32'd1);
    rst_4 = 1'b0;
    #1;
    check_eq("l4 async rst rbusy", 32'(rbusy_4), 32'd0);
    check_eq("l4 async rst rdata", rdata_4, 32'd0);
    saw_ready = 1'b0;
    repeat (2) begin
      tick();
      saw_ready |= ready_4;
    end
    rst_4 = 1'b1;
    repeat (4) begin
      tick();
      saw_ready |= ready_4;
    end
    check_eq("l4 aborted no ready", 32'(saw_ready), 32'd0);
    check_eq("l4 aborted rdata", rdata_4, 32'd0);
    rd4(32'h24, 4'd0, 32'd0, 1'b0, d, lat, busy, e);
    check_eq("l4 wait write dropped", d, 32'h0BAD_F00D);

    // ---------------- report ----------------
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
